// File: rtl/edge_frame_ctrl.sv
// rtl/edge_frame_ctrl.sv - frame timing, config shadowing and window mask for the Sobel edge path
//
// Tracks HDMI timing with a vsync-framed state machine and pixel/line counters,
// holds host configuration in shadow registers that become active at vsync rise,
// clears the line buffers at frame start and produces a border-suppressing window
// mask aligned with the datapath latency.
//
// Ports:
//   clk, reset                      pixel clock, asynchronous active-high reset
//   hdmi_de/hdmi_vsync/hdmi_hsync   input video timing (sync active-high)
//   cfg_wr/cfg_addr/cfg_wdata       host register write port
//   cfg_rdata                       registered read data for cfg_addr
//   x_cnt, y_cnt                    current pixel column / row
//   win_valid                       3x3 window-complete mask, delayed by LAT
//   lb_clr                          one-cycle line-buffer clear at frame start
//   frame_done                      one-cycle pulse when a non-empty frame ends
//   mode_act, en_act, thresh_act    active datapath configuration

module edge_frame_ctrl #(
  parameter int X_W        = 12,
  parameter int Y_W        = 11,
  parameter int LAT        = 2,
  parameter int THRESH_RST = 1300
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           hdmi_de,
  input  logic           hdmi_vsync,
  input  logic           hdmi_hsync,
  input  logic           cfg_wr,
  input  logic [1:0]     cfg_addr,
  input  logic [15:0]    cfg_wdata,
  output logic [15:0]    cfg_rdata,
  output logic [X_W-1:0] x_cnt,
  output logic [Y_W-1:0] y_cnt,
  output logic           win_valid,
  output logic           lb_clr,
  output logic           frame_done,
  output logic [1:0]     mode_act,
  output logic           en_act,
  output logic [11:0]    thresh_act
);

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_IN_VS   = 2'd1,
    S_FRAME   = 2'd2
  } state_t;

  localparam logic [X_W-1:0] X_MAX       = '1;
  localparam logic [Y_W-1:0] Y_MAX       = '1;
  localparam logic [11:0]    THRESH_INIT = 12'(THRESH_RST);

  state_t           r_state, w_state_nx;
  logic             r_vs_q, r_de_q;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [X_W-1:0]   r_line_len;
  logic             r_line_err;
  logic [15:0]      r_frame_cnt;
  logic [1:0]       r_mode_sh, r_mode_act;
  logic             r_en_sh, r_en_act;
  logic [11:0]      r_thresh_sh, r_thresh_act;
  logic             r_lb_clr, r_frame_done;
  logic [LAT-1:0]   r_win_sr;
  logic [15:0]      r_rdata;

  logic             w_vs_rise, w_de_fall, w_in_frame, w_line_end;
  logic             w_wr_ctrl, w_wr_thresh, w_err_clr, w_err_set, w_raw;
  logic [15:0]      w_rd_mux;
  logic             w_unused;

  assign w_vs_rise   = hdmi_vsync & ~r_vs_q;
  assign w_de_fall   = ~hdmi_de & r_de_q;
  assign w_in_frame  = (r_state == S_FRAME);
  // A vsync rise restarts the frame, so it overrides a coincident line end.
  assign w_line_end  = w_in_frame & ~w_vs_rise & w_de_fall;
  assign w_wr_ctrl   = cfg_wr & (cfg_addr == 2'd0);
  assign w_wr_thresh = cfg_wr & (cfg_addr == 2'd1);
  assign w_err_clr   = cfg_wr & (cfg_addr == 2'd2) & cfg_wdata[15];
  // The first line of a frame (r_y == 0) has nothing to compare against.
  assign w_err_set   = (w_line_end & (r_y != '0) & (r_x != r_line_len)) |
                       (hdmi_de & hdmi_hsync);
  assign w_raw       = hdmi_de & w_in_frame & (r_x >= X_W'(2)) & (r_y >= Y_W'(2));
  assign w_unused    = ^cfg_wdata[14:12];

  always_comb begin
    w_state_nx = r_state;
    if (w_vs_rise) begin
      w_state_nx = S_IN_VS;
    end else if ((r_state == S_IN_VS) && !hdmi_vsync) begin
      w_state_nx = S_FRAME;
    end
  end

  // Shadow reads bypass a same-cycle write so the new value reads back next cycle.
  always_comb begin
    w_rd_mux = '0;
    case (cfg_addr)
      2'd0: begin
        w_rd_mux[1:0] = w_wr_ctrl ? cfg_wdata[1:0] : r_mode_sh;
        w_rd_mux[2]   = w_wr_ctrl ? cfg_wdata[2]   : r_en_sh;
      end
      2'd1:    w_rd_mux[11:0] = w_wr_thresh ? cfg_wdata[11:0] : r_thresh_sh;
      2'd2: begin
        w_rd_mux[X_W-1:0] = r_line_len;
        w_rd_mux[15]      = r_line_err;
      end
      default: w_rd_mux = r_frame_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT_VS;
      r_vs_q       <= 1'b0;
      r_de_q       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_line_len   <= '0;
      r_line_err   <= 1'b0;
      r_frame_cnt  <= '0;
      r_mode_sh    <= 2'd1;
      r_en_sh      <= 1'b1;
      r_thresh_sh  <= THRESH_INIT;
      r_mode_act   <= 2'd1;
      r_en_act     <= 1'b1;
      r_thresh_act <= THRESH_INIT;
      r_lb_clr     <= 1'b0;
      r_frame_done <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_vs_q       <= hdmi_vsync;
      r_de_q       <= hdmi_de;
      r_lb_clr     <= w_vs_rise;
      r_frame_done <= w_vs_rise & w_in_frame & (r_y != '0);
      r_frame_cnt  <= r_frame_cnt + 16'(w_vs_rise);
      r_rdata      <= w_rd_mux;
      r_line_err   <= (r_line_err & ~w_err_clr) | w_err_set;

      if (w_vs_rise) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_in_frame) begin
        if (hdmi_de) begin
          if (r_x != X_MAX) r_x <= r_x + 1'b1;
        end else if (w_de_fall) begin
          r_x <= '0;
          if (r_y != Y_MAX) r_y <= r_y + 1'b1;
        end
      end
      if (w_line_end) r_line_len <= r_x;

      // Active copies sample the shadows before any same-cycle write lands.
      if (w_vs_rise) begin
        r_mode_act   <= r_mode_sh;
        r_en_act     <= r_en_sh;
        r_thresh_act <= r_thresh_sh;
      end
      if (w_wr_ctrl) begin
        r_mode_sh <= cfg_wdata[1:0];
        r_en_sh   <= cfg_wdata[2];
      end
      if (w_wr_thresh) r_thresh_sh <= cfg_wdata[11:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_sr <= '0;
    end else begin
      r_win_sr[0] <= w_raw;
      for (int i = 1; i < LAT; i++) r_win_sr[i] <= r_win_sr[i-1];
    end
  end

  assign cfg_rdata  = r_rdata;
  assign x_cnt      = r_x;
  assign y_cnt      = r_y;
  assign win_valid  = r_win_sr[LAT-1];
  assign lb_clr     = r_lb_clr;
  assign frame_done = r_frame_done;
  assign mode_act   = r_mode_act;
  assign en_act     = r_en_act;
  assign thresh_act = r_thresh_act;

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// tb/tb_edge_frame_ctrl.sv - scoreboard bench for edge_frame_ctrl
module tb_edge_frame_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hdmi_de = 1'b0, hdmi_vsync = 1'b0, hdmi_hsync = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic [15:0] cfg_rdata;
  logic [11:0] x_cnt;
  logic [10:0] y_cnt;
  logic        win_valid, lb_clr, frame_done, en_act;
  logic [1:0]  mode_act;
  logic [11:0] thresh_act;

  edge_frame_ctrl #(.X_W(12), .Y_W(11), .LAT(LAT), .THRESH_RST(1300)) dut (
    .clk(clk), .reset(reset),
    .hdmi_de(hdmi_de), .hdmi_vsync(hdmi_vsync), .hdmi_hsync(hdmi_hsync),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .win_valid(win_valid), .lb_clr(lb_clr),
    .frame_done(frame_done), .mode_act(mode_act), .en_act(en_act), .thresh_act(thresh_act)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0, win_seen = 0;
  int q_win[$], q_lb[$], q_fd[$];

  // reference model state
  int   m_st, m_x, m_y, m_len;
  bit   m_err, m_vs_prev, m_de_prev;
  logic [15:0] m_fcnt;
  int   m_mode_s, m_en_s, m_thr_s, m_mode_a, m_en_a, m_thr_a;
  bit   pend_wr = 0;
  int   pend_addr, pend_data;
  int   lens[$];
  int   wr_line = -1, wr_a, wr_d;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 0; m_y = 0; m_len = 0; m_err = 0;
    m_vs_prev = 0; m_de_prev = 0; m_fcnt = 16'd0;
    m_mode_s = 1; m_en_s = 1; m_thr_s = 1300;
    m_mode_a = 1; m_en_a = 1; m_thr_a = 1300;
    q_win.delete(); q_lb.delete(); q_fd.delete();
  endtask

  function automatic int m_rd(input int a);
    case (a)
      0: return m_mode_s | (m_en_s << 2);
      1: return m_thr_s;
      2: return (m_err ? 32768 : 0) | m_len;
      default: return int'(m_fcnt);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel-clock cycle of stimulus; the model advances by the same cycle.
  task automatic step(input bit vs, input bit de, input bit hs);
    bit rise, setf, clr;
    hdmi_vsync = vs; hdmi_de = de; hdmi_hsync = hs;
    cfg_wr = pend_wr;
    if (pend_wr) begin
      cfg_addr = 2'(pend_addr); cfg_wdata = 16'(pend_data);
    end
    rise = vs && !m_vs_prev;
    setf = de && hs;
    clr  = pend_wr && pend_addr == 2 && pend_data[15];
    if (de && m_st == 2 && m_x >= 2 && m_y >= 2) q_win.push_back(cyc + LAT);
    if (rise) begin
      q_lb.push_back(cyc + 1);
      if (m_st == 2 && m_y > 0) q_fd.push_back(cyc + 1);
      m_fcnt = m_fcnt + 16'd1;
      m_mode_a = m_mode_s; m_en_a = m_en_s; m_thr_a = m_thr_s;
      m_st = 1; m_x = 0; m_y = 0;
    end else begin
      if (m_st == 2) begin
        if (de) begin
          if (m_x < 4095) m_x++;
        end else if (m_de_prev) begin
          if (m_y > 0 && m_x != m_len) setf = 1;
          m_len = m_x; m_x = 0;
          if (m_y < 2047) m_y++;
        end
      end
      if (m_st == 1 && !vs) m_st = 2;
    end
    if (pend_wr && pend_addr == 0) begin m_mode_s = pend_data & 3; m_en_s = (pend_data >> 2) & 1; end
    if (pend_wr && pend_addr == 1) m_thr_s = pend_data & 4095;
    m_err = (m_err && !clr) || setf;
    pend_wr = 0;
    m_vs_prev = vs; m_de_prev = de;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic rd_exp(input string nm, input int a, input int exp);
    cfg_addr = 2'(a);
    step(0, 0, 0);
    chk(nm, int'(cfg_rdata), exp);
  endtask

  task automatic rd(input int a);
    cfg_addr = 2'(a);
    step(0, 0, 0);
    chk($sformatf("rd%0d", a), int'(cfg_rdata), m_rd(a));
  endtask

  task automatic wr(input int a, input int d);
    pend_wr = 1; pend_addr = a; pend_data = d;
    step(0, 0, 0);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("mode_act", int'(mode_act), m_mode_a);
    chk("en_act", int'(en_act), m_en_a);
    chk("thresh_act", int'(thresh_act), m_thr_a);
  endtask

  task automatic frame(input int gap);
    vsync_pulse();
    foreach (lens[i]) begin
      if (i == wr_line) begin pend_wr = 1; pend_addr = wr_a; pend_data = wr_d; end
      for (int k = 0; k < lens[i]; k++) begin
        step(0, 1, 0);
        if (k == 4500) chk("x_sat", int'(x_cnt), 4095);
      end
      for (int g = 0; g < gap; g++) step(0, 0, g == 1);
    end
    wr_line = -1;
  endtask

  // Scoreboard monitor: each output pulse must match the head of its queue.
  always @(negedge clk) begin
    while (q_win.size() > 0 && q_win[0] < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL win_valid missed: got 0 expected 1 at cycle %0d", q_win.pop_front());
    end
    if (win_valid) begin
      win_seen++; n_tests++;
      if (q_win.size() > 0 && q_win[0] == cyc) void'(q_win.pop_front());
      else begin n_fail++; $display("FAIL win_valid unexpected: got 1 expected 0 at cycle %0d", cyc); end
    end
    while (q_lb.size() > 0 && q_lb[0] < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL lb_clr missed: got 0 expected 1 at cycle %0d", q_lb.pop_front());
    end
    if (lb_clr) begin
      n_tests++;
      if (q_lb.size() > 0 && q_lb[0] == cyc) void'(q_lb.pop_front());
      else begin n_fail++; $display("FAIL lb_clr unexpected: got 1 expected 0 at cycle %0d", cyc); end
    end
    while (q_fd.size() > 0 && q_fd[0] < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL frame_done missed: got 0 expected 1 at cycle %0d", q_fd.pop_front());
    end
    if (frame_done) begin
      n_tests++;
      if (q_fd.size() > 0 && q_fd[0] == cyc) void'(q_fd.pop_front());
      else begin n_fail++; $display("FAIL frame_done unexpected: got 1 expected 0 at cycle %0d", cyc); end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, n, base;
    model_reset();
    tick(); tick();
    chk("rst_rdata", int'(cfg_rdata), 0);
    chk("rst_x", int'(x_cnt), 0);
    chk("rst_y", int'(y_cnt), 0);
    chk("rst_win_lb_fd", int'({win_valid, lb_clr, frame_done}), 0);
    chk("rst_mode", int'(mode_act), 1);
    chk("rst_en", int'(en_act), 1);
    chk("rst_thresh", int'(thresh_act), 1300);
    reset = 1'b0;
    step(0, 0, 0);
    rd_exp("ctrl_rst", 0, 5);
    rd_exp("thresh_rst", 1, 1300);
    rd_exp("len_rst", 2, 0);
    rd_exp("fcnt_rst", 3, 0);

    // 6x8 frame with a mid-frame THRESH write
    w0 = win_seen;
    lens = '{8, 8, 8, 8, 8, 8};
    wr_line = 3; wr_a = 1; wr_d = 500;
    frame(4);
    chk("win_count", win_seen - w0, 24);
    chk("y_after_frame", int'(y_cnt), 6);
    chk("thresh_held", int'(thresh_act), 1300);
    rd_exp("line_len8", 2, 8);
    rd_exp("fcnt1", 3, 1);
    rd_exp("thresh_shadow", 1, 500);

    // 8,8,7 -> line_err, then clear
    lens = '{8, 8, 7};
    frame(3);
    chk("thresh_applied", int'(thresh_act), 500);
    rd_exp("line_err", 2, 16'h8007);
    wr(2, 16'h8000);
    rd_exp("line_err_clr", 2, 7);

    // write coinciding with the vsync rise applies a frame later
    pend_wr = 1; pend_addr = 0; pend_data = 2;
    lens = '{4};
    frame(3);
    chk("coincide_mode", int'(mode_act), 1);
    chk("coincide_en", int'(en_act), 1);
    rd_exp("coincide_rd", 0, 2);
    frame(3);
    chk("later_mode", int'(mode_act), 2);
    chk("later_en", int'(en_act), 0);

    // randomized frames with occasional writes
    for (int f = 0; f < 12; f++) begin
      lens.delete();
      n = $urandom_range(1, 5);
      base = $urandom_range(3, 12);
      for (int i = 0; i < n; i++)
        lens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(3, 12) : base);
      if ($urandom_range(0, 2) == 0) begin
        wr_line = $urandom_range(0, n - 1);
        wr_a = $urandom_range(0, 3);
        wr_d = $urandom_range(0, 65535);
      end
      frame($urandom_range(2, 6));
      for (int a = 0; a < 4; a++) rd(a);
    end

    // 5000-pixel line saturates x_cnt
    wr(2, 16'h8000);
    lens = '{5000};
    frame(3);
    rd(2);
    chk("line_len_sat", int'(cfg_rdata[11:0]), 4095);

    // reset in the middle of line y=2 at x=5
    vsync_pulse();
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 8; k++) step(0, 1, 0);
      for (int g = 0; g < 3; g++) step(0, 0, 0);
    end
    for (int k = 0; k < 5; k++) step(0, 1, 0);
    chk("x_before_rst", int'(x_cnt), 5);
    hdmi_de = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_x", int'(x_cnt), 0);
    chk("mid_rst_y", int'(y_cnt), 0);
    chk("mid_rst_win", int'(win_valid), 0);
    chk("mid_rst_thresh", int'(thresh_act), 1300);
    chk("mid_rst_mode", int'(mode_act), 1);
    chk("mid_rst_rdata", int'(cfg_rdata), 0);
    model_reset();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) step(0, 1, 0);
    for (int g = 0; g < 3; g++) step(0, 0, 0);
    chk("no_count_wait", int'(x_cnt), 0);

    // de during hsync flags line_err even outside a frame
    step(0, 1, 1);
    step(0, 0, 0);
    rd_exp("hs_err", 2, 16'h8000);

    // recovery frame and closing vsync
    lens = '{6, 6, 6, 6};
    frame(3);
    vsync_pulse();
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    rd(3);
    chk("q_win_empty", q_win.size(), 0);
    chk("q_lb_empty", q_lb.size(), 0);
    chk("q_fd_empty", q_fd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
